crc_checker_wide: RTL
=====================

Name: crc_checker_wide

Overview:
- Parametrised successor to the 8-bit GMII FCS checker. Checks Ethernet FCS on a frame stream DATA_W bits wide, with a byte-masked final beat.
- Also reports runt frames and PHY-signalled aborts, and keeps saturating good-frame and error counters.
- Sits after SFD stripping in the RX MAC. Its input is the frame from destination MAC through FCS, inclusive.

Parameters:
- DATA_W, 32, stream width in bits. Must be a multiple of 8, range 8..64.
- KEEP_W, DATA_W/8, byte-lane count. Derived; do not override.
- MIN_FRAME_BYTES, 64, minimum legal frame length including FCS.
- LEN_W, 16, width of the internal byte-length counter. The counter saturates.
- CNT_W, 32, width of the statistics counters. The counters saturate.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- data_i  in  DATA_W  frame data; byte 0 (first on wire) in bits [7:0]
- valid_i  in  1  beat qualifier
- last_i  in  1  final beat of frame; qualified by valid_i
- keep_i  in  KEEP_W  valid byte lanes on the last beat; contiguous from lane 0; ignored on non-last beats (all lanes valid)
- rx_er_i  in  1  PHY receive error, sampled whenever valid_i=1
- stat_clear_i  in  1  synchronous clear of both statistics counters
- result_valid_o  out  1  one-cycle pulse per completed frame
- crc_error_o  out  1  FCS residue mismatch; qualified by result_valid_o
- runt_o  out  1  frame shorter than MIN_FRAME_BYTES; qualified by result_valid_o
- aborted_o  out  1  rx_er_i seen during frame; qualified by result_valid_o
- frame_len_o  out  LEN_W  byte count of the frame including FCS; qualified by result_valid_o
- good_cnt_o  out  CNT_W  frames with no error, no runt, no abort
- crc_err_cnt_o  out  CNT_W  frames with crc_error_o=1

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, CRC register = CRC_REG_INITIAL_VALUE, length = 0, all outputs 0, both counters 0. Reset mid-frame discards the frame; no result is emitted for it.
- State IDLE:
  - A valid_i beat starts a frame. The CRC is seeded from the initial value, length = number of bytes in the beat.
  - Go to ACTIVE, unless last_i=1 (single-beat frame), in which case the frame completes in that same beat.
- State ACTIVE:
  - Each valid beat updates the CRC over all lanes and adds KEEP_W to the length. On the last beat only, the update covers only the lanes set in keep_i, and the length grows by popcount(keep_i).
  - valid_i=0 is a gap: state, CRC and length hold. There is no timeout.
- Abort: rx_er_i=1 on any valid beat sets a sticky abort flag for the frame. The CRC keeps updating, so length stays exact. The frame completes normally on last_i.
- Completion, registered with 1-cycle latency: the cycle after the last beat, result_valid_o=1 and the following are set:
  - crc_error_o = (final CRC != CRC_RESIDUE) && !aborted.
  - runt_o = length < MIN_FRAME_BYTES.
  - aborted_o = the abort flag.
  - frame_len_o = the frame length.
- Outputs outside result_valid_o: crc_error_o, runt_o and aborted_o are driven to 0. frame_len_o holds its last value.
- Back-to-back frames: a new frame's first beat is accepted in the cycle immediately after last_i. The CRC and length re-seed with no bubble.
- keep_i=0 on the last beat is legal and means zero bytes from that beat. If the frame has no bytes at all, it reports length 0, runt_o=1 and crc_error_o=1.
- Length counter: saturates at 2^LEN_W-1 and does not wrap.
- Counters:
  - good_cnt_o increments on result when crc_error_o=0, runt_o=0 and aborted_o=0.
  - crc_err_cnt_o increments on result when crc_error_o=1.
  - Both saturate at all-ones.
  - If stat_clear_i is asserted in the same cycle as an increment, the clear wins: the counter goes to 0 and that event is not counted.

Decomposition:
- Add to crc_pkg:
  - crc_wide_state_t (IDLE, ACTIVE).
  - A keep-to-byte-count function.
  - Reuse CRC_W, CRC_REG_INITIAL_VALUE and CRC_RESIDUE.
- One sub-module, crc_lane_update:
  - Combinational; takes the old CRC, data and keep, and returns the new CRC.
  - Built from one calculate_new_crc instance per possible byte count (DATA_W=8·k for k=1..KEEP_W). The output is selected by keep_i on last beats, and the full-width result is used otherwise.
- Statistics counters: use a local saturating counter, or a shared sat_counter if one exists.

Test Plan:
- Good frame: DATA_W=32, 64-byte frame with correct FCS, 16 beats, keep=4'hF on last -> one cycle after last, result_valid_o=1, crc_error_o=0, runt_o=0, frame_len_o=64, good_cnt_o=1.
- Partial last beat: 65-byte frame with correct FCS, keep=4'b0001 on last -> frame_len_o=65, crc_error_o=0. Repeat with byte 20 bit 3 flipped -> crc_error_o=1, crc_err_cnt_o=1.
- Runt with valid FCS: 60-byte frame -> runt_o=1, crc_error_o=0; neither counter increments.
- Abort: rx_er_i pulsed on beat 5 of a 64-byte bad-FCS frame -> aborted_o=1, crc_error_o=0, no counter change. Valid gaps of 3 cycles inserted mid-frame -> same result as without gaps.
- Back-to-back and reset:
  - Two good 64-byte frames with zero idle between them -> two result pulses 16 cycles apart, good_cnt_o=2.
  - rst_n low mid-frame, then a good frame -> exactly one result, counters = 1/0.
- Counter edges: CNT_W=2, five good frames -> good_cnt_o=3. Then stat_clear_i coincident with a good result -> good_cnt_o=0.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC-32 (IEEE 802.3) definitions for the FCS checkers.
// Reflected (LSB-first) register convention: the register starts at all-ones,
// bytes are folded in LSB first, and a frame that includes its own FCS leaves
// the fixed residue CRC_RESIDUE in the register.
package crc_pkg;

  localparam int unsigned CRC_W = 32;
  localparam logic [CRC_W-1:0] CRC_REG_INITIAL_VALUE = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC_RESIDUE           = 32'hDEBB_20E3;
  localparam logic [CRC_W-1:0] CRC_POLY_REFLECTED    = 32'hEDB8_8320;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } crc_wide_state_t;

  // Fold one byte into the running CRC register.
  function automatic logic [CRC_W-1:0] calculate_new_crc(input logic [CRC_W-1:0] crc,
                                                         input logic [7:0]       data);
    logic [CRC_W-1:0] c;
    c = crc ^ {{(CRC_W-8){1'b0}}, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFLECTED) : (c >> 1);
    end
    return c;
  endfunction

  // Number of valid byte lanes in a keep mask (up to 8 lanes).
  function automatic logic [3:0] keep_count(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/crc_lane_update.sv
// Combinational multi-byte CRC-32 update.
// Ports:
//   crc_i  - CRC register before this beat
//   data_i - beat data, lane 0 in bits [7:0]
//   keep_i - valid lanes on a last beat (contiguous from lane 0)
//   last_i - beat is the final beat of a frame
//   crc_o  - CRC register after folding in the valid lanes
module crc_lane_update
  import crc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  output logic [CRC_W-1:0]  crc_o
);

  // Slice k holds the CRC after folding in lanes 0..k-1; slice 0 is the input.
  logic [(KEEP_W+1)*CRC_W-1:0] crc_by_len;
  logic [3:0]                  n_bytes;

  assign crc_by_len[CRC_W-1:0] = crc_i;

  for (genvar k = 1; k <= KEEP_W; k++) begin : g_len
    logic [CRC_W-1:0] crc_k;
    always_comb begin
      crc_k = crc_i;
      for (int b = 0; b < k; b++) begin
        crc_k = calculate_new_crc(crc_k, data_i[8*b +: 8]);
      end
    end
    assign crc_by_len[k*CRC_W +: CRC_W] = crc_k;
  end

  assign n_bytes = last_i ? keep_count(8'(keep_i)) : 4'(KEEP_W);

  always_comb begin
    crc_o = crc_by_len[KEEP_W*CRC_W +: CRC_W];
    for (int k = 0; k <= KEEP_W; k++) begin
      if (n_bytes == 4'(k)) begin
        crc_o = crc_by_len[k*CRC_W +: CRC_W];
      end
    end
  end

endmodule

// File: rtl/crc_checker_wide.sv
// Wide Ethernet FCS checker with runt/abort detection and saturating stats.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   data_i/valid_i/last_i - frame beats (DA through FCS), lane 0 first on wire
//   keep_i                - valid lanes on the last beat only
//   rx_er_i               - PHY error, sampled on valid beats
//   stat_clear_i          - synchronous clear of both counters (wins over increment)
//   result_valid_o        - one-cycle pulse, cycle after the last beat
//   crc_error_o/runt_o/aborted_o/frame_len_o - per-frame result
//   good_cnt_o/crc_err_cnt_o - saturating statistics
module crc_checker_wide
  import crc_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned KEEP_W          = DATA_W / 8,
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned LEN_W           = 16,
  parameter int unsigned CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              rx_er_i,
  input  logic              stat_clear_i,
  output logic              result_valid_o,
  output logic              crc_error_o,
  output logic              runt_o,
  output logic              aborted_o,
  output logic [LEN_W-1:0]  frame_len_o,
  output logic [CNT_W-1:0]  good_cnt_o,
  output logic [CNT_W-1:0]  crc_err_cnt_o
);

  localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_FRAME_BYTES);

  crc_wide_state_t  state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             abort_q, abort_d;

  logic             result_valid_q, result_valid_d;
  logic             crc_error_q, crc_error_d;
  logic             runt_q, runt_d;
  logic             aborted_q, aborted_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [CRC_W-1:0] crc_base, crc_new;
  logic [LEN_W-1:0] len_base, len_new;
  logic [LEN_W:0]   len_sum;
  logic [3:0]       beat_bytes;
  logic             abort_base, abort_new;
  logic             good_inc, err_inc;

  // A beat seen in idle starts a new frame, so it folds onto fresh seeds.
  assign crc_base   = (state_q == StIdle) ? CRC_REG_INITIAL_VALUE : crc_q;
  assign len_base   = (state_q == StIdle) ? '0 : len_q;
  assign abort_base = (state_q == StIdle) ? 1'b0 : abort_q;

  crc_lane_update #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_lane_update (
    .crc_i  (crc_base),
    .data_i (data_i),
    .keep_i (keep_i),
    .last_i (last_i),
    .crc_o  (crc_new)
  );

  assign beat_bytes = last_i ? keep_count(8'(keep_i)) : 4'(KEEP_W);
  assign len_sum    = {1'b0, len_base} + (LEN_W+1)'(beat_bytes);
  assign len_new    = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  assign abort_new  = abort_base | rx_er_i;

  always_comb begin
    state_d        = state_q;
    crc_d          = crc_q;
    len_d          = len_q;
    abort_d        = abort_q;
    result_valid_d = 1'b0;
    crc_error_d    = 1'b0;
    runt_d         = 1'b0;
    aborted_d      = 1'b0;
    frame_len_d    = frame_len_q;
    if (valid_i) begin
      if (last_i) begin
        state_d        = StIdle;
        crc_d          = CRC_REG_INITIAL_VALUE;
        len_d          = '0;
        abort_d        = 1'b0;
        result_valid_d = 1'b1;
        // An aborted frame's FCS is meaningless, so it is not blamed on the CRC.
        crc_error_d    = (crc_new != CRC_RESIDUE) && !abort_new;
        runt_d         = len_new < MinLen;
        aborted_d      = abort_new;
        frame_len_d    = len_new;
      end else begin
        state_d = StActive;
        crc_d   = crc_new;
        len_d   = len_new;
        abort_d = abort_new;
      end
    end
  end

  // Counters move on the same edge that publishes the result.
  assign good_inc = result_valid_d & ~crc_error_d & ~runt_d & ~aborted_d;
  assign err_inc  = result_valid_d & crc_error_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (stat_clear_i) begin
      good_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (good_inc && (good_cnt_q != '1)) good_cnt_d = good_cnt_q + CNT_W'(1);
      if (err_inc && (err_cnt_q != '1))   err_cnt_d  = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      crc_q          <= CRC_REG_INITIAL_VALUE;
      len_q          <= '0;
      abort_q        <= 1'b0;
      result_valid_q <= 1'b0;
      crc_error_q    <= 1'b0;
      runt_q         <= 1'b0;
      aborted_q      <= 1'b0;
      frame_len_q    <= '0;
      good_cnt_q     <= '0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      crc_q          <= crc_d;
      len_q          <= len_d;
      abort_q        <= abort_d;
      result_valid_q <= result_valid_d;
      crc_error_q    <= crc_error_d;
      runt_q         <= runt_d;
      aborted_q      <= aborted_d;
      frame_len_q    <= frame_len_d;
      good_cnt_q     <= good_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign result_valid_o = result_valid_q;
  assign crc_error_o    = crc_error_q;
  assign runt_o         = runt_q;
  assign aborted_o      = aborted_q;
  assign frame_len_o    = frame_len_q;
  assign good_cnt_o     = good_cnt_q;
  assign crc_err_cnt_o  = err_cnt_q;

endmodule
